// File: rtl/fp52_pkg.sv
// fp52_pkg: constants and types shared by the fp(2,5) result re-encoder.
// Holds the operand field widths, the exponent range of the MAC op_c
// path, the {dat,exp} operand type and the data saturation limits.
package fp52_pkg;

    localparam int RES_W   = 18;               // fixed-point MAC result width
    localparam int DAT_W   = 6;                // signed operand data width
    localparam int EXP_W   = 3;                // operand exponent width
    localparam int EXP_MAX = 6;                // largest op_c shift
    localparam int CNT_W   = $clog2(RES_W);    // leading-sign count width

    localparam logic signed [DAT_W-1:0] DAT_POS_MAX = {1'b0, {(DAT_W-1){1'b1}}};
    localparam logic signed [DAT_W-1:0] DAT_NEG_MIN = {1'b1, {(DAT_W-1){1'b0}}};
    // 2^(DAT_W-2): data value after a rounding carry bumps the exponent
    localparam logic signed [DAT_W-1:0] DAT_RENORM  = {2'b01, {(DAT_W-2){1'b0}}};

    typedef struct packed {
        logic signed [DAT_W-1:0] dat;
        logic        [EXP_W-1:0] exp;
    } fp52_op_t;

    typedef struct packed {
        fp52_op_t op;
        logic     sat;
    } fp52_enc_t;

    // Smallest shift that fits the value into DAT_W bits, given the number of
    // redundant sign bits; limited to the op_c shift range.
    function automatic logic [EXP_W-1:0] e0_of(input logic [CNT_W-1:0] n);
        int t;
        t = RES_W - DAT_W - int'(n);
        if (t < 0)       t = 0;
        if (t > EXP_MAX) t = EXP_MAX;
        return EXP_W'(t);
    endfunction

endpackage

// File: rtl/fp52_res_enc_if.sv
// fp52_res_enc_if: handshake and data bundle of the result re-encoder.
//   in_vld/in_rdy/in_res           : fixed-point result input channel
//   out_vld/out_rdy/out_dat/out_exp/out_sat : encoded operand output channel
// slave  = re-encoder view, master = surrounding datapath / bench view.
interface fp52_res_enc_if;
    import fp52_pkg::*;

    logic                    in_vld;
    logic                    in_rdy;
    logic signed [RES_W-1:0] in_res;
    logic                    out_vld;
    logic                    out_rdy;
    logic signed [DAT_W-1:0] out_dat;
    logic        [EXP_W-1:0] out_exp;
    logic                    out_sat;

    modport slave  (input  in_vld, in_res, out_rdy,
                    output in_rdy, out_vld, out_dat, out_exp, out_sat);
    modport master (output in_vld, in_res, out_rdy,
                    input  in_rdy, out_vld, out_dat, out_exp, out_sat);

endinterface

// File: rtl/fp52_lsd.sv
// fp52_lsd: combinational leading-sign-bit counter.
//   val_i : RES_W-bit two's-complement value
//   cnt_o : number of bits directly below the MSB that equal the MSB
//           (0..RES_W-1); zero and -1 both give RES_W-1.
module fp52_lsd
    import fp52_pkg::*;
(
    input  logic [RES_W-1:0] val_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic run;

    always_comb begin
        cnt_o = '0;
        run   = 1'b1;
        for (int i = RES_W - 2; i >= 0; i--) begin
            if (run && (val_i[i] == val_i[RES_W-1])) cnt_o = cnt_o + CNT_W'(1);
            else                                     run   = 1'b0;
        end
    end

endmodule

// File: rtl/fp52_res_enc.sv
// fp52_res_enc: converts the 18-bit fixed-point MAC result into the
// {6-bit signed data, 3-bit exponent} op_c operand (value = dat * 2^exp).
// Three-stage valid/ready pipeline, one item per cycle, bubbles collapse.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fp52_res_enc_if.slave (in_* input channel, out_* output channel)
// Build option FP52_RES_ENC_RNE_EN: round to nearest even; otherwise the
// discarded bits are truncated (floor), like the MAC's arithmetic shift.
module fp52_res_enc
    import fp52_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fp52_res_enc_if.slave  bus
);

    logic                    vld_p1_q, vld_p2_q, vld_p3_q;
    logic                    en_p1, en_p2, en_p3;
    logic [CNT_W-1:0]        lsd_p1_d;
    logic [EXP_W-1:0]        e0_p1_d, e0_p1_q, e0_p2_q;
    logic signed [RES_W-1:0] res_p1_q;
    logic signed [RES_W-1:0] q_p2_d, q_p2_q;
    logic                    inc_p3_d;
    logic signed [RES_W:0]   r_p3_d;
    fp52_enc_t               enc_p3_d;
    fp52_op_t                op_p3_q;
    logic                    sat_p3_q;

    // A stage loads when empty or when its successor loads this cycle.
    always_comb begin
        en_p3 = !vld_p3_q || bus.out_rdy;
        en_p2 = !vld_p2_q || en_p3;
        en_p1 = !vld_p1_q || en_p2;
    end

    assign bus.in_rdy = en_p1;

    // Clip to the operand range; a positive rounding carry below EXP_MAX is
    // absorbed by moving one step up in exponent instead of saturating.
    function automatic fp52_enc_t sat_enc(input logic signed [RES_W:0] r,
                                          input logic [EXP_W-1:0] e0);
        fp52_enc_t o;
        o.sat    = 1'b0;
        o.op.exp = e0;
        o.op.dat = r[DAT_W-1:0];
        if (int'(r) > int'(DAT_POS_MAX)) begin
            if (int'(e0) < EXP_MAX) begin
                o.op.dat = DAT_RENORM;
                o.op.exp = e0 + EXP_W'(1);
            end else begin
                o.op.dat = DAT_POS_MAX;
                o.op.exp = EXP_W'(EXP_MAX);
                o.sat    = 1'b1;
            end
        end else if (int'(r) < int'(DAT_NEG_MIN)) begin
            o.op.dat = DAT_NEG_MIN;
            o.op.exp = EXP_W'(EXP_MAX);
            o.sat    = 1'b1;
        end
        return o;
    endfunction

    // ---- stage 1: capture result, leading-sign detect, candidate exponent
    fp52_lsd u_lsd (
        .val_i (bus.in_res),
        .cnt_o (lsd_p1_d)
    );

    assign e0_p1_d = e0_of(lsd_p1_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            res_p1_q <= '0;
            e0_p1_q  <= '0;
        end else if (en_p1) begin
            vld_p1_q <= bus.in_vld;
            res_p1_q <= bus.in_res;
            e0_p1_q  <= e0_p1_d;
        end
    end

    // ---- stage 2: arithmetic shift by e0, keep the bits needed for rounding
    assign q_p2_d = res_p1_q >>> e0_p1_q;

`ifdef FP52_RES_ENC_RNE_EN
    logic g_p2_d, s_p2_d, g_p2_q, s_p2_q;

    always_comb begin
        g_p2_d = 1'b0;
        s_p2_d = 1'b0;
        for (int i = 0; i < EXP_MAX; i++) begin
            if (i == int'(e0_p1_q) - 1)     g_p2_d = res_p1_q[i];
            else if (i < int'(e0_p1_q) - 1) s_p2_d = s_p2_d | res_p1_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_p2_q <= 1'b0;
            s_p2_q <= 1'b0;
        end else if (en_p2) begin
            g_p2_q <= g_p2_d;
            s_p2_q <= s_p2_d;
        end
    end

    function automatic logic rne_inc(input logic q0, input logic g, input logic s);
        return g & (s | q0);
    endfunction

    assign inc_p3_d = rne_inc(q_p2_q[0], g_p2_q, s_p2_q);
`else
    // Truncation: the shifted-out bits are simply dropped.
    assign inc_p3_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2_q <= 1'b0;
            q_p2_q   <= '0;
            e0_p2_q  <= '0;
        end else if (en_p2) begin
            vld_p2_q <= vld_p1_q;
            q_p2_q   <= q_p2_d;
            e0_p2_q  <= e0_p1_q;
        end
    end

    // ---- stage 3: round, renormalise or saturate, register the operand
    assign r_p3_d   = $signed({q_p2_q[RES_W-1], q_p2_q}) + $signed({{RES_W{1'b0}}, inc_p3_d});
    assign enc_p3_d = sat_enc(r_p3_d, e0_p2_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p3_q <= 1'b0;
            op_p3_q  <= '0;
            sat_p3_q <= 1'b0;
        end else if (en_p3) begin
            vld_p3_q <= vld_p2_q;
            op_p3_q  <= enc_p3_d.op;
            sat_p3_q <= enc_p3_d.sat;
        end
    end

    assign bus.out_vld = vld_p3_q;
    assign bus.out_dat = op_p3_q.dat;
    assign bus.out_exp = op_p3_q.exp;
    assign bus.out_sat = sat_p3_q;

endmodule

// File: tb/tb_fp52_res_enc.sv
// tb_fp52_res_enc: self-checking bench for fp52_res_enc. Directed cases from
// the encoding rules, stall/reset behaviour, then randomized traffic against
// an arithmetic reference model through an in-order scoreboard.
module tb_fp52_res_enc;
    import fp52_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fp52_res_enc_if bus ();

    fp52_res_enc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dat;
        int ex;
        int sat;
        int res;
        int acc;
    } item_t;

    item_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc_n = 0;
    int    n_out = 0;
    bit    lat_chk   = 1'b0;
    bit    hold_prev = 1'b0;
    int    prev_dat, prev_exp, prev_sat;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, expv);
        end
    endtask

    // Reference: pick the smallest shift whose floor fits DAT_W bits (capped at
    // EXP_MAX), round the discarded part, then fix up a carry or clip.
    function automatic item_t model(input int res);
        item_t it;
        int e, q, rem, half;
        e = 0;
        while (e < EXP_MAX && ((res >>> e) > 31 || (res >>> e) < -32)) e++;
        q = res >>> e;
`ifdef FP52_RES_ENC_RNE_EN
        if (e > 0) begin
            rem  = res - q * (1 << e);
            half = 1 << (e - 1);
            if (rem > half || (rem == half && (q % 2) != 0)) q++;
        end
`endif
        it.res = res;
        it.sat = 0;
        it.acc = 0;
        if (q > 31) begin
            if (e < EXP_MAX) begin it.dat = 16; it.ex = e + 1; end
            else begin it.dat = 31; it.ex = EXP_MAX; it.sat = 1; end
        end else if (q < -32) begin
            it.dat = -32; it.ex = EXP_MAX; it.sat = 1;
        end else begin
            it.dat = q; it.ex = e;
        end
        return it;
    endfunction

    // One clock cycle: drive, sample, score, advance to 1 time unit past the edge.
    task automatic cyc(input logic v, input int res, input logic ordy,
                       input bit dir, input int edat, input int eexp, input int esat,
                       output logic acc);
        item_t it;
        int    err, ok;
        bus.in_vld  = v;
        bus.in_res  = res[RES_W-1:0];
        bus.out_rdy = ordy;
        #1;
        acc = v & bus.in_rdy;
        if (hold_prev) begin
            chk("hold_vld", int'(bus.out_vld), 1);
            chk("hold_dat", int'(bus.out_dat), prev_dat);
            chk("hold_exp", int'(bus.out_exp), prev_exp);
            chk("hold_sat", int'(bus.out_sat), prev_sat);
        end
        hold_prev = bus.out_vld & ~ordy;
        prev_dat  = int'(bus.out_dat);
        prev_exp  = int'(bus.out_exp);
        prev_sat  = int'(bus.out_sat);
        if (bus.out_vld && ordy) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                it = exp_q.pop_front();
                chk("dat", int'(bus.out_dat), it.dat);
                chk("exp", int'(bus.out_exp), it.ex);
                chk("sat", int'(bus.out_sat), it.sat);
                if (lat_chk) chk("latency", cyc_n - it.acc, 3);
                if (!bus.out_sat) begin
                    err = it.res - int'(bus.out_dat) * (1 << int'(bus.out_exp));
`ifdef FP52_RES_ENC_RNE_EN
                    ok = (2 * err <= (1 << int'(bus.out_exp)) &&
                          -2 * err <= (1 << int'(bus.out_exp))) ? 1 : 0;
`else
                    ok = (err >= 0 && err < (1 << int'(bus.out_exp))) ? 1 : 0;
`endif
                    chk("err_bound", ok, 1);
                end
            end
        end
        if (acc) begin
            if (dir) begin
                it.dat = edat; it.ex = eexp; it.sat = esat; it.res = res;
            end else begin
                it = model(res);
            end
            it.acc = cyc_n;
            exp_q.push_back(it);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) cyc(1'b0, 0, 1'b1, 1'b0, 0, 0, 0, a);
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic dir1(input int res, input int edat, input int eexp, input int esat);
        logic a;
        cyc(1'b1, res, 1'b1, 1'b1, edat, eexp, esat, a);
        chk("dir_acc", int'(a), 1);
    endtask

    initial begin
        logic a;
        int   k, base, x;
        int   items[6];

        bus.in_vld  = 1'b0;
        bus.in_res  = '0;
        bus.out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", int'(bus.out_vld), 0);
        chk("rst_dat", int'(bus.out_dat), 0);
        chk("rst_exp", int'(bus.out_exp), 0);
        chk("rst_sat", int'(bus.out_sat), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_rdy", int'(bus.in_rdy), 1);

        // Back-to-back directed values, fixed 3-cycle latency
        lat_chk = 1'b1;
        dir1(0, 0, 0, 0);
        dir1(25, 25, 0, 0);
        dir1(100, 25, 2, 0);
        dir1(-64, -32, 1, 0);
`ifdef FP52_RES_ENC_RNE_EN
        dir1(63, 16, 2, 0);
`else
        dir1(63, 31, 1, 0);
`endif
        dir1(4000, 31, 6, 1);
        dir1(-131072, -32, 6, 1);
        dir1(1984, 31, 6, 0);
        dir1(-1, -1, 0, 0);
        dir1(131071, 31, 6, 1);
        drain();
        lat_chk = 1'b0;

        // Output stall: three accepted, then backpressure; order preserved
        for (int i = 0; i < 6; i++) items[i] = 100 * (i + 1) - 250;
        k = 0;
        base = 0;
        for (int c = 0; c < 40 && (k < 6 || exp_q.size() > 0); c++) begin
            if (c == 5) base = n_out;
            cyc(k < 6, items[k < 6 ? k : 0], c >= 5, 1'b0, 0, 0, 0, a);
            if (a) k++;
            if (c == 3) chk("stall_in_rdy", int'(bus.in_rdy), 0);
            if (c == 4) chk("stall_acc", k, 3);
            if (c == 10) chk("release_burst", n_out - base, 6);
        end
        chk("stall_all_acc", k, 6);
        chk("stall_left", exp_q.size(), 0);

        // Asynchronous reset with three items in flight
        for (int i = 0; i < 3; i++) cyc(1'b1, 37 * (i + 1), 1'b0, 1'b0, 0, 0, 0, a);
        chk("pre_rst_vld", int'(bus.out_vld), 1);
        rst = 1'b1;
        #2;
        chk("async_rst_vld", int'(bus.out_vld), 0);
        chk("async_rst_dat", int'(bus.out_dat), 0);
        chk("async_rst_exp", int'(bus.out_exp), 0);
        chk("async_rst_sat", int'(bus.out_sat), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        hold_prev = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b0, 0, 1'b1, 1'b0, 0, 0, 0, a);
        chk("post_rst_vld", int'(bus.out_vld), 0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 10000; i++) begin
            x = int'($urandom);
            x = x >>> $urandom_range(14, 31);
            cyc($urandom_range(0, 3) != 0, x, $urandom_range(0, 9) < 7, 1'b0, 0, 0, 0, a);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp52_res_enc.md
Name: fp52_res_enc

Overview:
- Re-encoder on the output side of the fp(2,5) fused multiply-add datapath.
- Takes the 18-bit two's-complement fixed-point MAC result and converts it back into the 6-bit signed data + 3-bit exponent pair the MAC consumes on its addend (op_c) port.
- Operand meaning: value = dat × 2^exp, in result-LSB units.
- 3-stage valid/ready pipeline. Sits between the MAC result register and the operand write-back/FIFO.

Parameters:
- RES_W, 18: input fixed-point result width.
- DAT_W, 6: output signed data width.
- EXP_W, 3: output exponent width.
- EXP_MAX, 6: largest legal output exponent, equal to the MAC op_c shift range.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- in_vld  input  1  input result valid
- in_rdy  output  1  block accepts input this cycle
- in_res  input  RES_W  signed fixed-point result
- out_vld  output  1  encoded operand valid
- out_rdy  input  1  downstream accepts output
- out_dat  output  DAT_W  signed encoded data
- out_exp  output  EXP_W  encoded exponent, 0..EXP_MAX
- out_sat  output  1  result was clipped to the representable range

Behaviour:
- Reset (async, active-high):
  - All stage valids clear, so out_vld=0.
  - out_dat=0, out_exp=0, out_sat=0.
  - Stage data registers clear.
  - A reset mid-operation drops all in-flight items; no output for them.
- Handshake:
  - Transfer occurs when vld & rdy are both high on the same clk edge.
  - Stage i loads when its valid is 0 or stage i+1 loads (stage 4 = out_rdy). in_rdy = stage-1 load enable, combinational.
  - Full throughput is 1 item/cycle. Latency is 3 cycles from input transfer to out_vld with no stall.
  - Bubbles collapse. Output data stays stable while out_vld=1 and out_rdy=0.
  - Order is preserved.
- Stage 1:
  - Register in_res.
  - Leading-sign detect: n = count of redundant sign bits (0..RES_W-1).
  - Candidate exponent e0 = max(0, RES_W - DAT_W - n), clamped to EXP_MAX.
- Stage 2:
  - Arithmetic shift right by e0, giving integer part q.
  - Keep guard bit g (bit e0-1) and sticky s (OR of bits below); g=s=0 when e0=0.
- Stage 3: rounding with the selected mode gives r = q + inc.
  - If r > 2^(DAT_W-1)-1 (rounding overflow, positive side only) and e0 < EXP_MAX: exp = e0+1, dat = 2^(DAT_W-2) (=16).
  - If r is out of range at e0 = EXP_MAX: saturate. dat = 31 for positive, -32 for negative; exp = EXP_MAX; out_sat = 1.
  - Any value whose truncated magnitude exceeds range at EXP_MAX also saturates.
  - Otherwise dat = r, exp = e0, out_sat = 0.
- Encoding is minimal-exponent: the smallest e with the rounded result in [-32,31].
- Zero encodes as dat=0, exp=0.
- -32 is representable at any exponent; e.g. -64 gives dat=-32, exp=1.
- Round-trip requirement: re-expanding dat × 2^exp through the MAC op_c path reproduces in_res exactly whenever out_sat=0 and g=s=0.

Optional Feature:
- FP52_RES_ENC_RNE_EN defined: round-to-nearest-even. inc = g & (s | q[0]).
- Undefined: truncation toward negative infinity, matching the MAC's arithmetic right shift. inc = 0, rounding overflow cannot occur, and stage 3 is only the saturation check.
- Latency stays 3 in both builds.

Decomposition:
- Shared package fp52_pkg:
  - RES_W, DAT_W, EXP_W, EXP_MAX constants.
  - Typedef for the {dat,exp} operand pair.
  - Saturation limit constants DAT_POS_MAX=31 and DAT_NEG_MIN=-32.
- One sub-module fp52_lsd: combinational leading-sign-bit counter, RES_W in, clog2(RES_W)-bit count out. Reused by any future normaliser.

Test Plan:
- Reset asserted mid-stream with 3 items in flight -> out_vld=0 immediately (async); after release no stale outputs; out_dat/out_exp/out_sat=0.
- in_res=0, 25, 100, -64 back-to-back, out_rdy=1 -> outputs (0,0), (25,0), (25,2), (-32,1) on consecutive cycles starting 3 cycles after the first accept; out_sat=0.
- in_res=63 -> RNE build: (16,2); truncate build: (31,1).
- in_res=4000 and -131072 -> (31,6,sat=1) and (-32,6,sat=1). in_res=1984 -> (31,6,sat=0).
- out_rdy held 0 for 5 cycles while feeding 6 items -> in_rdy falls after 3 accepted; out_dat stable. On release, all 6 emerge in order, one per cycle, none lost or duplicated.
- Random 10k in_res with random out_rdy -> scoreboard against the reference model. Re-expanded dat × 2^exp is within ½ LSB of 2^exp (RNE) of in_res whenever out_sat=0.
